sram_rw_port_arbiter: RTL and testbench

- Shares the single read/write port (port 0) of the 32x512 byte-masked dual-port SRAM macro between two requesters, A and B (e.g. core load/store and DMA/bus bridge).
- Arbitration is round-robin with a valid/ready request handshake.
- The block drives the macro's active-low csb0/web0, wmask0, addr0 and din0, and returns dout0 to the winning requester with fixed one-cycle latency.
- Port 1 (read-only) of the macro is not touched.

---
 rtl/sram_rw_port_arbiter.sv | 110 +++++++++++
 tb/tb_sram_rw_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the read/write port of a byte-masked SRAM macro between two requesters.
// Optional per-requester grant / conflict counters are enabled with SRAM_ARB_STATS_EN.
module sram_rw_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_a_grants,
  output logic [15:0]           stat_b_grants,
  output logic [15:0]           stat_conflicts
`endif
);

  logic prio_b;
  logic grant_a, grant_b;
  logic rsp_vld, rsp_own_b, rsp_rd;

  assign grant_a = !rst && a_req_valid && (!b_req_valid || !prio_b);
  assign grant_b = !rst && b_req_valid && (!a_req_valid ||  prio_b);

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_ff @(posedge clk) begin
    if (rst)          prio_b <= 1'b0;
    else if (grant_a) prio_b <= 1'b1;
    else if (grant_b) prio_b <= 1'b0;
  end

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (grant_a) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~a_req_we;
      sram_wmask0 = a_req_we ? a_req_wmask : '0;
      sram_addr0  = a_req_addr;
      sram_din0   = a_req_wdata;
    end else if (grant_b) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~b_req_we;
      sram_wmask0 = b_req_we ? b_req_wmask : '0;
      sram_addr0  = b_req_addr;
      sram_din0   = b_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld   <= 1'b0;
      rsp_own_b <= 1'b0;
      rsp_rd    <= 1'b0;
    end else begin
      rsp_vld   <= grant_a || grant_b;
      rsp_own_b <= grant_b;
      rsp_rd    <= grant_a ? !a_req_we : !b_req_we;
    end
  end

  // Gating with rst drops a response whose slot coincides with reset assertion.
  assign a_rsp_valid = rsp_vld && !rsp_own_b && !rst;
  assign b_rsp_valid = rsp_vld &&  rsp_own_b && !rst;
  assign a_rsp_rdata = (a_rsp_valid && rsp_rd) ? sram_dout0 : '0;
  assign b_rsp_rdata = (b_rsp_valid && rsp_rd) ? sram_dout0 : '0;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_a_grants  <= '0;
      stat_b_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (grant_a && stat_a_grants != 16'hFFFF) stat_a_grants <= stat_a_grants + 16'd1;
      if (grant_b && stat_b_grants != 16'hFFFF) stat_b_grants <= stat_b_grants + 16'd1;
      if (a_req_valid && b_req_valid && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Scoreboard bench for sram_rw_port_arbiter: reference model predicts grants and responses,
// a monitor pops expectations whenever a response appears. Build with SRAM_ARB_STATS_EN to check counters.
module tb_sram_rw_port_arbiter;

  typedef struct { logic we; logic [3:0] m; logic [8:0] addr; logic [31:0] d; } req_t;
  typedef struct { bit own_b; logic [31:0] data; int due; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic av, bv;
  req_t ar, br;
  logic a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic sram_csb0, sram_web0;
  logic [3:0] sram_wmask0;
  logic [8:0] sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_a_grants, stat_b_grants, stat_conflicts;
`endif

  int tests = 0, fails = 0, cyc = 0;
  exp_t q[$];
  bit mprio_b;
  bit a_acc, b_acc;
  logic [31:0] refmem [512];
  logic [31:0] smem [512];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_rw_port_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req_valid(av), .a_req_ready(a_req_ready), .a_req_we(ar.we), .a_req_wmask(ar.m),
    .a_req_addr(ar.addr), .a_req_wdata(ar.d), .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(bv), .b_req_ready(b_req_ready), .b_req_we(br.we), .b_req_wmask(br.m),
    .b_req_addr(br.addr), .b_req_wdata(br.d), .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
`ifdef SRAM_ARB_STATS_EN
    , .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  // Macro model: latched at the rising edge, read data appears for the following cycle.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) smem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
      end else begin
        sram_dout0 <= smem[sram_addr0];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_rsp_valid && b_rsp_valid) begin
        chk("both_rsp_valid", 1, 0);
      end else if (a_rsp_valid || b_rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_owner", b_rsp_valid, e.own_b);
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_rdata", b_rsp_valid ? b_rsp_rdata : a_rsp_rdata, e.data);
          chk("rsp_other_rdata", b_rsp_valid ? a_rsp_rdata : b_rsp_rdata, 0);
        end
      end else begin
        chk("idle_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
        if (q.size() != 0 && q[0].due <= cyc) begin
          chk("missing_rsp", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  // Check this cycle against the model, advance the model, then move to just after the next edge.
  task automatic cycle();
    bit ga, gb;
    req_t r;
    exp_t e;
    @(negedge clk);
    a_acc = 0; b_acc = 0;
    if (rst) begin
      chk("rst_ready", {a_req_ready, b_req_ready}, 0);
      chk("rst_csb0", sram_csb0, 1);
      chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    end else begin
      ga = av && (!bv || !mprio_b);
      gb = bv && (!av ||  mprio_b);
      chk("a_ready", a_req_ready, ga);
      chk("b_ready", b_req_ready, gb);
      if (ga || gb) begin
        r = ga ? ar : br;
        chk("csb0", sram_csb0, 0);
        chk("web0", sram_web0, !r.we);
        chk("addr0", sram_addr0, r.addr);
        chk("wmask0", sram_wmask0, r.we ? r.m : 4'h0);
        chk("din0", sram_din0, r.d);
        e.own_b = gb;
        e.due = cyc + 1;
        if (r.we) begin
          e.data = 0;
          for (int i = 0; i < 4; i++)
            if (r.m[i]) refmem[r.addr][8*i +: 8] = r.d[8*i +: 8];
        end else e.data = refmem[r.addr];
        q.push_back(e);
        mprio_b = ga;
        a_acc = ga; b_acc = gb;
      end else begin
        chk("idle_drive", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0}, {2'b11, 45'h0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic assert_rst();
    rst = 1; av = 0; bv = 0; q.delete(); mprio_b = 0;
  endtask

  function automatic req_t mk(input logic we, input logic [3:0] m, input logic [8:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.m = m; r.addr = a; r.d = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    logic [8:0] a;
    a = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
    return mk(1'($urandom), 4'($urandom), a, $urandom);
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin refmem[i] = 0; smem[i] = 0; end
    sram_dout0 = 0;
    ar = mk(0, 0, 0, 0); br = mk(0, 0, 0, 0);
    assert_rst();
    @(posedge clk); #1;

    // Reset then idle
    cycle(); cycle();
    rst = 0;
    cycle(); cycle();

    // A write then read-back, back-to-back
    av = 1; ar = mk(1, 4'hF, 9'h005, 32'hDEADBEEF); cycle();
    ar = mk(0, 4'hF, 9'h005, 32'h0); cycle();
    av = 0; cycle();
    chk("raw_model", refmem[5], 32'hDEADBEEF);

    // Byte mask merge
    av = 1; ar = mk(1, 4'hF, 9'h1FF, 32'h11223344); cycle();
    ar = mk(1, 4'b0101, 9'h1FF, 32'hAABBCCDD); cycle();
    ar = mk(1, 4'h0, 9'h1FF, 32'hFFFFFFFF); cycle();
    ar = mk(0, 4'hF, 9'h1FF, 32'h0); cycle();
    av = 0; cycle();
    chk("mask_model", refmem[9'h1FF], 32'h11BB33DD);

    // Contention right after reset
    assert_rst(); cycle(); rst = 0;
    av = 1; bv = 1;
    ar = mk(0, 4'hF, 9'h005, 0); br = mk(0, 4'hF, 9'h1FF, 0);
    for (int i = 0; i < 6; i++) cycle();
    av = 0; bv = 0; cycle(); cycle();
`ifdef SRAM_ARB_STATS_EN
    chk("stat_a_grants", stat_a_grants, 3);
    chk("stat_b_grants", stat_b_grants, 3);
    chk("stat_conflicts", stat_conflicts, 6);
`endif

    // Reset while a B read is in flight
    bv = 1; br = mk(0, 4'hF, 9'h005, 0); cycle();
    assert_rst(); cycle(); cycle();
    rst = 0; av = 1; bv = 1;
    ar = mk(0, 4'hF, 9'h1FF, 0); br = mk(0, 4'hF, 9'h005, 0);
    cycle();
    chk("post_rst_a_first", a_acc, 1);
    av = 0; bv = 0; cycle(); cycle();

    // Randomised traffic: requesters hold payload until accepted
    for (int n = 0; n < 400; n++) begin
      if (!av && $urandom_range(0, 9) < 6) begin av = 1; ar = rnd_req(); end
      if (!bv && $urandom_range(0, 9) < 6) begin bv = 1; br = rnd_req(); end
      cycle();
      if (a_acc) av = 0;
      if (b_acc) bv = 0;
    end
    av = 0; bv = 0;
    cycle(); cycle();
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
